id_stage_pipe: RTL and testbench

Pipelined successor to the single-cycle decode stage for the RISC-V core. It accepts instructions from IF over a valid/ready handshake and decodes them: control, immediate generation and ALU control. It reads a 32-entry register file with write-back bypass, detects load-use hazards and inserts bubbles on stall or flush. It sits between IF and EX and drives a registered ID/EX bundle with one cycle of latency.

---
 rtl/id_stage_pipe.sv | 204 ++++++++++++++++++++
 tb/tb_id_stage_pipe.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_pipe.sv
// Pipelined RISC-V decode stage: decode, register file with write-back bypass,
// load-use hazard detection and a registered ID/EX bundle.
module id_stage_pipe #(
    parameter int WIDTH     = 32,
    parameter bit BYPASS    = 1'b1,
    parameter bit HAZARD_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_valid,
    input  logic [31:0]      if_instr,
    input  logic [WIDTH-1:0] if_pc,
    output logic             id_ready,
    input  logic             ex_flush,
    input  logic             wb_regWrite,
    input  logic [4:0]       wb_rd,
    input  logic [WIDTH-1:0] wb_data,
    output logic             ex_valid,
    output logic [WIDTH-1:0] ex_pc,
    output logic [WIDTH-1:0] ex_rs1_data,
    output logic [WIDTH-1:0] ex_rs2_data,
    output logic [WIDTH-1:0] ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic             ex_branch,
    output logic             ex_memRead,
    output logic             ex_memToReg,
    output logic             ex_memWrite,
    output logic             ex_ALUSrc,
    output logic             ex_regWrite,
    output logic [3:0]       ex_ALUControl,
    output logic             ex_illegal
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic [WIDTH-1:0] r_regs [32];

    logic [6:0]       w_opcode;
    logic [2:0]       w_funct3;
    logic             w_funct7b5;
    logic [4:0]       w_rs1, w_rs2, w_rd;
    logic             w_legal, w_use_rs1, w_use_rs2;
    logic             w_branch, w_memRead, w_memToReg, w_memWrite, w_ALUSrc, w_regWrite;
    logic [3:0]       w_alu;
    logic [WIDTH-1:0] w_imm;
    logic [WIDTH-1:0] w_rs1_data, w_rs2_data;
    logic             w_stall, w_accept, w_load, w_take_illegal;

    assign w_opcode   = if_instr[6:0];
    assign w_funct3   = if_instr[14:12];
    assign w_funct7b5 = if_instr[30];
    assign w_rs1      = if_instr[19:15];
    assign w_rs2      = if_instr[24:20];
    assign w_rd       = if_instr[11:7];

    always_comb begin
        w_legal    = 1'b0;
        w_use_rs1  = 1'b0;
        w_use_rs2  = 1'b0;
        w_branch   = 1'b0;
        w_memRead  = 1'b0;
        w_memToReg = 1'b0;
        w_memWrite = 1'b0;
        w_ALUSrc   = 1'b0;
        w_regWrite = 1'b0;
        w_alu      = 4'b0000;
        w_imm      = '0;
        case (w_opcode)
            OP_R: begin
                w_use_rs1  = 1'b1;
                w_use_rs2  = 1'b1;
                w_regWrite = 1'b1;
                case ({w_funct7b5, w_funct3})
                    4'b0_000: begin w_legal = 1'b1; w_alu = 4'b0010; end
                    4'b1_000: begin w_legal = 1'b1; w_alu = 4'b0110; end
                    4'b0_111: begin w_legal = 1'b1; w_alu = 4'b0000; end
                    4'b0_110: begin w_legal = 1'b1; w_alu = 4'b0001; end
                    default: ;
                endcase
            end
            OP_I: begin
                w_use_rs1  = 1'b1;
                w_ALUSrc   = 1'b1;
                w_regWrite = 1'b1;
                w_imm      = {{(WIDTH-12){if_instr[31]}}, if_instr[31:20]};
                case (w_funct3)
                    3'b000: begin w_legal = 1'b1; w_alu = 4'b0010; end
                    3'b111: begin w_legal = 1'b1; w_alu = 4'b0000; end
                    3'b110: begin w_legal = 1'b1; w_alu = 4'b0001; end
                    default: ;
                endcase
            end
            OP_LOAD: begin
                w_legal    = 1'b1;
                w_use_rs1  = 1'b1;
                w_ALUSrc   = 1'b1;
                w_memRead  = 1'b1;
                w_memToReg = 1'b1;
                w_regWrite = 1'b1;
                w_alu      = 4'b0010;
                w_imm      = {{(WIDTH-12){if_instr[31]}}, if_instr[31:20]};
            end
            OP_STORE: begin
                w_legal    = 1'b1;
                w_use_rs1  = 1'b1;
                w_use_rs2  = 1'b1;
                w_ALUSrc   = 1'b1;
                w_memWrite = 1'b1;
                w_alu      = 4'b0010;
                w_imm      = {{(WIDTH-12){if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
            end
            OP_BRANCH: begin
                w_legal   = 1'b1;
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_branch  = 1'b1;
                w_alu     = 4'b0110;
                w_imm     = {{(WIDTH-13){if_instr[31]}}, if_instr[31], if_instr[7],
                             if_instr[30:25], if_instr[11:8], 1'b0};
            end
            default: ;
        endcase
    end

    // Same-cycle write-back is visible to the read ports only when BYPASS is set.
    always_comb begin
        w_rs1_data = r_regs[w_rs1];
        if (w_rs1 == 5'd0)
            w_rs1_data = '0;
        else if (BYPASS && wb_regWrite && (wb_rd == w_rs1))
            w_rs1_data = wb_data;
    end

    always_comb begin
        w_rs2_data = r_regs[w_rs2];
        if (w_rs2 == 5'd0)
            w_rs2_data = '0;
        else if (BYPASS && wb_regWrite && (wb_rd == w_rs2))
            w_rs2_data = wb_data;
    end

    assign w_stall = HAZARD_EN && ex_valid && ex_memRead && (ex_rd != 5'd0)
                     && ((w_use_rs1 && (w_rs1 == ex_rd)) || (w_use_rs2 && (w_rs2 == ex_rd)))
                     && if_valid && !ex_flush;

    assign id_ready       = !w_stall && !rst;
    assign w_accept       = if_valid && !ex_flush && !w_stall;
    assign w_load         = w_accept && w_legal;
    assign w_take_illegal = w_accept && !w_legal;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) r_regs[i] <= '0;
        end else if (wb_regWrite && (wb_rd != 5'd0)) begin
            r_regs[wb_rd] <= wb_data;
        end
    end

    // Anything that does not load a decoded instruction leaves a zeroed bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid      <= 1'b0;
            ex_illegal    <= 1'b0;
            ex_pc         <= '0;
            ex_rs1_data   <= '0;
            ex_rs2_data   <= '0;
            ex_imm        <= '0;
            ex_rs1        <= '0;
            ex_rs2        <= '0;
            ex_rd         <= '0;
            ex_branch     <= 1'b0;
            ex_memRead    <= 1'b0;
            ex_memToReg   <= 1'b0;
            ex_memWrite   <= 1'b0;
            ex_ALUSrc     <= 1'b0;
            ex_regWrite   <= 1'b0;
            ex_ALUControl <= '0;
        end else begin
            ex_valid      <= w_load;
            ex_illegal    <= w_take_illegal;
            ex_pc         <= w_load ? if_pc      : '0;
            ex_rs1_data   <= w_load ? w_rs1_data : '0;
            ex_rs2_data   <= w_load ? w_rs2_data : '0;
            ex_imm        <= w_load ? w_imm      : '0;
            ex_rs1        <= w_load ? w_rs1      : '0;
            ex_rs2        <= w_load ? w_rs2      : '0;
            ex_rd         <= w_load ? w_rd       : '0;
            ex_branch     <= w_load && w_branch;
            ex_memRead    <= w_load && w_memRead;
            ex_memToReg   <= w_load && w_memToReg;
            ex_memWrite   <= w_load && w_memWrite;
            ex_ALUSrc     <= w_load && w_ALUSrc;
            ex_regWrite   <= w_load && w_regWrite;
            ex_ALUControl <= w_load ? w_alu : 4'b0000;
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
module tb_id_stage_pipe;

   localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_L = 7'b0000011;

   logic        clk = 1'b0;
   logic        rst, if_valid, ex_flush, wb_regWrite;
   logic [31:0] if_instr, if_pc, wb_data;
   logic [4:0]  wb_rd;

   logic        id_ready, ex_valid, ex_branch, ex_memRead, ex_memToReg, ex_memWrite;
   logic        ex_ALUSrc, ex_regWrite, ex_illegal;
   logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
   logic [4:0]  ex_rs1, ex_rs2, ex_rd;
   logic [3:0]  ex_ALUControl;

   logic        nb_id_ready, nb_ex_valid, nb_ex_branch, nb_ex_memRead, nb_ex_memToReg, nb_ex_memWrite;
   logic        nb_ex_ALUSrc, nb_ex_regWrite, nb_ex_illegal;
   logic [31:0] nb_ex_pc, nb_ex_rs1_data, nb_ex_rs2_data, nb_ex_imm;
   logic [4:0]  nb_ex_rs1, nb_ex_rs2, nb_ex_rd;
   logic [3:0]  nb_ex_ALUControl;

   always #5 clk = ~clk;

   id_stage_pipe #(.WIDTH(32), .BYPASS(1'b1), .HAZARD_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
      .id_ready(id_ready), .ex_flush(ex_flush), .wb_regWrite(wb_regWrite), .wb_rd(wb_rd),
      .wb_data(wb_data), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
      .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
      .ex_rd(ex_rd), .ex_branch(ex_branch), .ex_memRead(ex_memRead),
      .ex_memToReg(ex_memToReg), .ex_memWrite(ex_memWrite), .ex_ALUSrc(ex_ALUSrc),
      .ex_regWrite(ex_regWrite), .ex_ALUControl(ex_ALUControl), .ex_illegal(ex_illegal)
   );

   id_stage_pipe #(.WIDTH(32), .BYPASS(1'b0), .HAZARD_EN(1'b1)) dut_nb (
      .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
      .id_ready(nb_id_ready), .ex_flush(ex_flush), .wb_regWrite(wb_regWrite), .wb_rd(wb_rd),
      .wb_data(wb_data), .ex_valid(nb_ex_valid), .ex_pc(nb_ex_pc), .ex_rs1_data(nb_ex_rs1_data),
      .ex_rs2_data(nb_ex_rs2_data), .ex_imm(nb_ex_imm), .ex_rs1(nb_ex_rs1), .ex_rs2(nb_ex_rs2),
      .ex_rd(nb_ex_rd), .ex_branch(nb_ex_branch), .ex_memRead(nb_ex_memRead),
      .ex_memToReg(nb_ex_memToReg), .ex_memWrite(nb_ex_memWrite), .ex_ALUSrc(nb_ex_ALUSrc),
      .ex_regWrite(nb_ex_regWrite), .ex_ALUControl(nb_ex_ALUControl), .ex_illegal(nb_ex_illegal)
   );

   typedef struct packed {
      logic legal, u1, u2, branch, memRead, memToReg, memWrite, ALUSrc, regWrite;
      logic [3:0]  alu;
      logic [31:0] imm;
   } dec_t;

   typedef struct packed {
      logic        valid, illegal, u2;
      logic [31:0] pc, rs1d, rs2d, rs1d_nb, rs2d_nb;
      logic [4:0]  rs1, rs2, rd;
      dec_t        d;
   } bundle_t;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] m_regs [32];
   bundle_t     m_ex;
   logic        obs_ready;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic dec_t model_decode(input logic [31:0] ins);
      dec_t        d;
      logic [31:0] sx;
      d = '0;
      case (ins[6:0])
         7'b0110011: begin
            d.u1 = 1; d.u2 = 1; d.regWrite = 1;
            if      (ins[14:12] == 3'd0 && !ins[30]) begin d.legal = 1; d.alu = 4'd2; end
            else if (ins[14:12] == 3'd0 &&  ins[30]) begin d.legal = 1; d.alu = 4'd6; end
            else if (ins[14:12] == 3'd7 && !ins[30]) begin d.legal = 1; d.alu = 4'd0; end
            else if (ins[14:12] == 3'd6 && !ins[30]) begin d.legal = 1; d.alu = 4'd1; end
         end
         7'b0010011: begin
            d.u1 = 1; d.ALUSrc = 1; d.regWrite = 1;
            d.imm = $signed(ins) >>> 20;
            if      (ins[14:12] == 3'd0) begin d.legal = 1; d.alu = 4'd2; end
            else if (ins[14:12] == 3'd7) begin d.legal = 1; d.alu = 4'd0; end
            else if (ins[14:12] == 3'd6) begin d.legal = 1; d.alu = 4'd1; end
         end
         7'b0000011: begin
            d.legal = 1; d.u1 = 1; d.ALUSrc = 1; d.memRead = 1; d.memToReg = 1;
            d.regWrite = 1; d.alu = 4'd2;
            d.imm = $signed(ins) >>> 20;
         end
         7'b0100011: begin
            d.legal = 1; d.u1 = 1; d.u2 = 1; d.ALUSrc = 1; d.memWrite = 1; d.alu = 4'd2;
            sx = $signed(ins) >>> 25;
            d.imm = (sx << 5) | 32'(ins[11:7]);
         end
         7'b1100011: begin
            d.legal = 1; d.u1 = 1; d.u2 = 1; d.branch = 1; d.alu = 4'd6;
            sx = $signed(ins) >>> 31;
            d.imm = (sx << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
         end
         default: ;
      endcase
      return d;
   endfunction

   function automatic logic [31:0] read_model(input logic [4:0] r, input bit byp, input logic wbw,
                                              input logic [4:0] wbrd, input logic [31:0] wbd);
      if (r == 5'd0) return 32'd0;
      if (byp && wbw && wbrd == r) return wbd;
      return m_regs[r];
   endfunction

   function automatic logic [12:0] ctl_vec(input bundle_t b);
      return {b.valid, b.d.branch, b.d.memRead, b.d.memToReg, b.d.memWrite, b.d.ALUSrc,
              b.d.regWrite, b.d.alu, b.illegal};
   endfunction

   function automatic logic [31:0] enc_r(input logic f7b5, input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
      return {1'b0, f7b5, 5'd0, rs2, rs1, f3, rd, OP_R};
   endfunction
   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction
   function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
      return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
   endfunction
   function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
      return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
   endfunction

   task automatic cmp_bundle();
      chk("ctl", {ex_valid, ex_branch, ex_memRead, ex_memToReg, ex_memWrite, ex_ALUSrc,
                  ex_regWrite, ex_ALUControl, ex_illegal}, ctl_vec(m_ex));
      chk("nb_ctl", {nb_ex_valid, nb_ex_branch, nb_ex_memRead, nb_ex_memToReg, nb_ex_memWrite,
                     nb_ex_ALUSrc, nb_ex_regWrite, nb_ex_ALUControl, nb_ex_illegal}, ctl_vec(m_ex));
      if (m_ex.valid) begin
         chk("pc_imm_rs1", {ex_pc, ex_imm, ex_rs1}, {m_ex.pc, m_ex.d.imm, m_ex.rs1});
         chk("nb_pc_imm_rs1", {nb_ex_pc, nb_ex_imm, nb_ex_rs1}, {m_ex.pc, m_ex.d.imm, m_ex.rs1});
         chk("rs1_data", ex_rs1_data, m_ex.rs1d);
         chk("nb_rs1_data", nb_ex_rs1_data, m_ex.rs1d_nb);
         if (m_ex.u2) begin
            chk("rs2", {ex_rs2, nb_ex_rs2}, {m_ex.rs2, m_ex.rs2});
            chk("rs2_data", ex_rs2_data, m_ex.rs2d);
            chk("nb_rs2_data", nb_ex_rs2_data, m_ex.rs2d_nb);
         end
         if (m_ex.d.regWrite) chk("rd", {ex_rd, nb_ex_rd}, {m_ex.rd, m_ex.rd});
      end
   endtask

   task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc, input logic fl,
                       input logic wbw, input logic [4:0] wbrd, input logic [31:0] wbd,
                       output logic taken);
      dec_t    d;
      bundle_t nxt;
      logic    stall;
      if_valid = v; if_instr = ins; if_pc = pc; ex_flush = fl;
      wb_regWrite = wbw; wb_rd = wbrd; wb_data = wbd;
      #1;
      d = model_decode(ins);
      stall = m_ex.valid && m_ex.d.memRead && m_ex.rd != 5'd0 && v && !fl &&
              ((d.u1 && ins[19:15] == m_ex.rd) || (d.u2 && ins[24:20] == m_ex.rd));
      obs_ready = id_ready;
      chk("id_ready", id_ready, !stall);
      chk("nb_id_ready", nb_id_ready, !stall);
      taken = v && !stall;
      nxt = '0;
      if (v && !fl && !stall) begin
         if (d.legal) begin
            nxt.valid   = 1'b1;
            nxt.d       = d;
            nxt.u2      = d.u2;
            nxt.pc      = pc;
            nxt.rs1     = ins[19:15];
            nxt.rs2     = ins[24:20];
            nxt.rd      = ins[11:7];
            nxt.rs1d    = read_model(ins[19:15], 1'b1, wbw, wbrd, wbd);
            nxt.rs2d    = read_model(ins[24:20], 1'b1, wbw, wbrd, wbd);
            nxt.rs1d_nb = read_model(ins[19:15], 1'b0, wbw, wbrd, wbd);
            nxt.rs2d_nb = read_model(ins[24:20], 1'b0, wbw, wbrd, wbd);
         end else begin
            nxt.illegal = 1'b1;
         end
      end
      @(posedge clk);
      if (wbw && wbrd != 5'd0) m_regs[wbrd] = wbd;
      m_ex = nxt;
      #1;
      cmp_bundle();
   endtask

   function automatic logic [31:0] rand_instr();
      logic [4:0]  a, b, c;
      logic [2:0]  f3;
      logic [11:0] imm;
      a   = 5'($urandom_range(0, 7));
      b   = 5'($urandom_range(0, 7));
      c   = 5'($urandom_range(0, 7));
      imm = 12'($urandom);
      f3  = 3'($urandom);
      case ($urandom_range(0, 6))
         0: return enc_r(1'($urandom), b, a, ($urandom_range(0, 2) == 0) ? f3 : 3'(6 + $urandom_range(0, 1)), c);
         1: return enc_i(imm, a, ($urandom_range(0, 2) == 0) ? f3 : 3'b000, c, OP_I);
         2, 6: return enc_i(imm, a, 3'b010, c, OP_L);
         3: return enc_s(imm, b, a);
         4: return enc_b({imm, 1'b0}, b, a);
         default: return {25'($urandom), 7'($urandom)};
      endcase
   endfunction

   initial begin
      logic        t;
      logic [31:0] cur, pc;
      bit          have;

      rst = 1'b1; if_valid = 1'b1; if_instr = enc_r(1'b0, 5'd2, 5'd1, 3'd0, 5'd3); if_pc = 32'h40;
      ex_flush = 1'b0; wb_regWrite = 1'b1; wb_rd = 5'd9; wb_data = 32'h1234;
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_ex = '0;
      #1;
      chk("rst_ready", id_ready, 1'b0);
      repeat (2) begin
         @(posedge clk); #1;
         chk("rst_ready", id_ready, 1'b0);
         chk("rst_ctl", {ex_valid, ex_branch, ex_memRead, ex_memToReg, ex_memWrite, ex_ALUSrc,
                         ex_regWrite, ex_ALUControl, ex_illegal}, 13'd0);
         chk("rst_data", {ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd}, 143'd0);
      end
      rst = 1'b0;

      for (int r = 1; r < 32; r++)
         step(1'b1, enc_r(1'b0, 5'(r), 5'(r), 3'd0, 5'd3), 32'(r * 4), 1'b0, 1'b0, 5'd0, 32'd0, t);

      step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 5'd1, 32'd5, t);
      step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 5'd2, 32'd7, t);
      step(1'b1, enc_r(1'b0, 5'd2, 5'd1, 3'd0, 5'd3), 32'h100, 1'b0, 1'b0, 5'd0, 32'd0, t);
      chk("add_rs", {ex_rs1_data, ex_rs2_data}, {32'd5, 32'd7});
      chk("add_ctl", {ex_ALUControl, ex_regWrite}, {4'b0010, 1'b1});
      step(1'b1, enc_s(12'd12, 5'd3, 5'd1), 32'h104, 1'b0, 1'b0, 5'd0, 32'd0, t);
      chk("sw", {ex_imm, ex_memWrite, ex_ALUSrc}, {32'd12, 1'b1, 1'b1});

      step(1'b1, enc_i(12'd0, 5'd1, 3'b010, 5'd4, OP_L), 32'h108, 1'b0, 1'b0, 5'd0, 32'd0, t);
      step(1'b1, enc_r(1'b0, 5'd2, 5'd4, 3'd0, 5'd5), 32'h10c, 1'b0, 1'b0, 5'd0, 32'd0, t);
      chk("lu_stall", {obs_ready, ex_valid}, 2'b00);
      step(1'b1, enc_r(1'b0, 5'd2, 5'd4, 3'd0, 5'd5), 32'h10c, 1'b0, 1'b0, 5'd0, 32'd0, t);
      chk("lu_issue", {obs_ready, ex_valid, ex_rs1, ex_pc}, {2'b11, 5'd4, 32'h10c});
      step(1'b1, enc_i(12'd0, 5'd1, 3'b010, 5'd4, OP_L), 32'h110, 1'b0, 1'b0, 5'd0, 32'd0, t);
      step(1'b1, enc_i(12'd1, 5'd0, 3'b000, 5'd5, OP_I), 32'h114, 1'b0, 1'b0, 5'd0, 32'd0, t);
      chk("lu_ctrl", {obs_ready, ex_valid, ex_imm}, {2'b11, 32'd1});

      step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 5'd6, 32'h11111111, t);
      step(1'b1, enc_r(1'b0, 5'd0, 5'd6, 3'd6, 5'd7), 32'h118, 1'b0, 1'b1, 5'd6, 32'hDEADBEEF, t);
      chk("bypass", ex_rs1_data, 32'hDEADBEEF);
      chk("no_bypass", nb_ex_rs1_data, 32'h11111111);
      step(1'b1, enc_r(1'b0, 5'd0, 5'd0, 3'd6, 5'd7), 32'h11c, 1'b0, 1'b1, 5'd0, 32'h55, t);
      step(1'b1, enc_r(1'b0, 5'd0, 5'd0, 3'd6, 5'd7), 32'h120, 1'b0, 1'b0, 5'd0, 32'd0, t);
      chk("x0", {ex_rs1_data, nb_ex_rs1_data}, 64'd0);

      step(1'b1, enc_i(12'd0, 5'd1, 3'b010, 5'd8, OP_L), 32'h124, 1'b0, 1'b0, 5'd0, 32'd0, t);
      step(1'b1, enc_b(13'd8, 5'd2, 5'd8), 32'h128, 1'b1, 1'b0, 5'd0, 32'd0, t);
      chk("flush", {obs_ready, ex_valid, ex_branch}, 3'b100);
      step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, t);
      chk("flush_nohold", ex_valid, 1'b0);

      step(1'b1, enc_b(13'h1FFC, 5'd2, 5'd1), 32'h12c, 1'b0, 1'b0, 5'd0, 32'd0, t);
      chk("beq", {ex_imm, ex_ALUControl}, {32'hFFFFFFFC, 4'b0110});
      step(1'b1, 32'h0000007F, 32'h130, 1'b0, 1'b0, 5'd0, 32'd0, t);
      chk("illegal", {ex_valid, ex_illegal}, 2'b01);
      step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, t);
      chk("illegal_pulse", ex_illegal, 1'b0);

      have = 0; pc = 32'h200; cur = '0;
      repeat (500) begin
         if (!have) begin cur = rand_instr(); have = 1; end
         step(($urandom_range(0, 4) != 0), cur, pc, ($urandom_range(0, 9) == 0),
              1'($urandom), 5'($urandom_range(0, 7)), $urandom, t);
         if (t) begin have = 0; pc += 4; end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
